// File: rtl/calculator_button_conditioner.sv
// Synchronises, debounces and auto-repeats the Basys3 push-buttons for the calculator.
// All outputs are registered; downstream logic acts on btn_pulse only.
module calculator_button_conditioner #(
  parameter int unsigned        NUM_BTN         = 5,
  parameter int unsigned        DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned        REPEAT_DELAY    = 50000000,
  parameter int unsigned        REPEAT_RATE     = 10000000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 5'b11000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               any_held
);

  localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [NUM_BTN-1:0] s1;
  logic [NUM_BTN-1:0] sync;
  logic [NUM_BTN-1:0] level_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      sync     <= '0;
      any_held <= 1'b0;
    end else begin
      s1       <= btn_raw;
      sync     <= s1;
      any_held <= |level_nxt;
    end
  end

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          lvl_q;
    logic          lvl_nxt;
    logic          rise;
    logic          pulse_q;
    logic [1:0]    rstate;
    logic [1:0]    rstate_nxt;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_nxt;
    logic          fire;

    // Any sample that agrees with the accepted level restarts the count.
    always_comb begin
      lvl_nxt = lvl_q;
      rise    = 1'b0;
      cnt_nxt = '0;
      if (sync[gi] != lvl_q) begin
        if (cnt == CNT_LAST) begin
          lvl_nxt = sync[gi];
          rise    = sync[gi];
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end

    // Driven from the next level so a release on a due edge suppresses that repeat.
    always_comb begin
      rstate_nxt = rstate;
      rcnt_nxt   = rcnt;
      fire       = 1'b0;
      if (!REPEAT_MASK[gi] || !lvl_nxt) begin
        rstate_nxt = ST_IDLE;
        rcnt_nxt   = '0;
      end else begin
        case (rstate)
          ST_IDLE: begin
            if (rise) begin
              rstate_nxt = ST_DELAY;
              rcnt_nxt   = '0;
            end
          end
          ST_DELAY: begin
            if (rcnt == DELAY_LAST) begin
              fire       = 1'b1;
              rcnt_nxt   = '0;
              rstate_nxt = ST_REPEAT;
            end else begin
              rcnt_nxt = rcnt + RW'(1);
            end
          end
          ST_REPEAT: begin
            if (rcnt == RATE_LAST) begin
              fire     = 1'b1;
              rcnt_nxt = '0;
            end else begin
              rcnt_nxt = rcnt + RW'(1);
            end
          end
          default: begin
            rstate_nxt = ST_IDLE;
            rcnt_nxt   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt     <= '0;
        lvl_q   <= 1'b0;
        pulse_q <= 1'b0;
        rstate  <= ST_IDLE;
        rcnt    <= '0;
      end else begin
        cnt     <= cnt_nxt;
        lvl_q   <= lvl_nxt;
        pulse_q <= rise | fire;
        rstate  <= rstate_nxt;
        rcnt    <= rcnt_nxt;
      end
    end

    assign level_nxt[gi] = lvl_nxt;
    assign btn_level[gi] = lvl_q;
    assign btn_pulse[gi] = pulse_q;
  end

endmodule

// File: tb/tb_calculator_button_conditioner.sv
// Bench for calculator_button_conditioner: stimulus table, directed corner cases and
// random traffic, all compared every cycle against a timing-rule reference model.
module tb_calculator_button_conditioner;

  localparam int unsigned NB = 5;
  localparam int          DB = 4;
  localparam int          RD = 10;
  localparam int          RR = 3;
  localparam logic [4:0]  MASK = 5'b11000;
  localparam int          TN = 18;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn_raw = '0;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;
  logic       any_held;

  calculator_button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .REPEAT_MASK    (MASK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .any_held (any_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] raw;
    logic [4:0] exp_level;
    logic [4:0] exp_pulse;
    logic       exp_any;
  } vec_t;

  vec_t tbl[TN];

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  // Reference model: raw reaches the debouncer two edges late; a level is accepted once
  // DB consecutive disagreeing samples follow the last quiet point; repeats fire at fixed
  // offsets from the press edge while the level is still held.
  logic [4:0] dly[$];
  int         quiet[NB];
  int         press_at[NB];
  logic [4:0] m_level = '0;
  logic [4:0] m_pulse = '0;
  logic       m_any = 1'b0;

  int         pq[NB][$];
  logic [4:0] lvl_seen;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_no, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [4:0] raw);
    logic [4:0] seen;
    int         d;
    if (r) begin
      dly = '{5'b0, 5'b0};
      m_level = '0;
      m_pulse = '0;
      m_any = 1'b0;
      for (int i = 0; i < NB; i++) begin
        quiet[i] = edge_no;
        press_at[i] = -1000;
      end
      return;
    end
    seen = dly.pop_front();
    dly.push_back(raw);
    m_pulse = '0;
    for (int i = 0; i < NB; i++) begin
      if (seen[i] == m_level[i]) begin
        quiet[i] = edge_no;
      end else if (edge_no - quiet[i] >= DB) begin
        m_level[i] = seen[i];
        quiet[i] = edge_no;
        if (seen[i]) begin
          m_pulse[i] = 1'b1;
          press_at[i] = edge_no;
        end
      end
      d = edge_no - press_at[i];
      if (m_level[i] && MASK[i] && d >= RD && ((d - RD) % RR) == 0)
        m_pulse[i] = 1'b1;
    end
    m_any = |m_level;
  endtask

  task automatic cycle(input logic r, input logic [4:0] raw);
    rst = r;
    btn_raw = raw;
    model_step(r, raw);
    @(negedge clk);
    chk("btn_level", int'(btn_level), int'(m_level));
    chk("btn_pulse", int'(btn_pulse), int'(m_pulse));
    chk("any_held", int'(any_held), int'(m_any));
    for (int i = 0; i < NB; i++)
      if (btn_pulse[i] === 1'b1) pq[i].push_back(edge_no);
    lvl_seen = lvl_seen | btn_level;
    edge_no++;
  endtask

  task automatic clr();
    for (int i = 0; i < NB; i++) pq[i].delete();
    lvl_seen = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 5'b0);
  endtask

  function automatic int pe(input int b, input int idx);
    if (idx < pq[b].size()) return pq[b][idx];
    return -1;
  endfunction

  initial begin
    int         k;
    int         rate;
    logic [4:0] raw_r;

    // btnC clean press and release; row 1 drives the raw edge, so edge offsets are row-1.
    for (int j = 0; j < TN; j++) begin
      tbl[j].rst       = (j == 0);
      tbl[j].raw       = (j >= 1 && j <= 10) ? 5'b00001 : 5'b00000;
      tbl[j].exp_level = (j >= 6 && j <= 15) ? 5'b00001 : 5'b00000;
      tbl[j].exp_pulse = (j == 6) ? 5'b00001 : 5'b00000;
      tbl[j].exp_any   = (j >= 6 && j <= 15);
    end

    dly = '{5'b0, 5'b0};
    clr();
    @(negedge clk);
    repeat (3) cycle(1'b1, 5'b0);
    chk("reset_level", int'(btn_level), 0);
    chk("reset_pulse", int'(btn_pulse), 0);
    chk("reset_any", int'(any_held), 0);

    for (int j = 0; j < TN; j++) begin
      cycle(tbl[j].rst, tbl[j].raw);
      chk("tbl_level", int'(btn_level), int'(tbl[j].exp_level));
      chk("tbl_pulse", int'(btn_pulse), int'(tbl[j].exp_pulse));
      chk("tbl_any", int'(any_held), int'(tbl[j].exp_any));
    end
    idle(5);

    // Bounce on btnL, then a steady hold.
    clr();
    cycle(1'b0, 5'b00100);
    cycle(1'b0, 5'b00000);
    cycle(1'b0, 5'b00100);
    cycle(1'b0, 5'b00000);
    chk("bounce_no_pulse", pq[2].size(), 0);
    k = edge_no;
    repeat (20) cycle(1'b0, 5'b00100);
    chk("bounce_count", pq[2].size(), 1);
    chk("bounce_edge", pe(2, 0), k + 5);
    idle(10);

    // Three-cycle glitch on btnR.
    clr();
    repeat (3) cycle(1'b0, 5'b00010);
    idle(10);
    chk("glitch_level", int'(lvl_seen[1]), 0);
    chk("glitch_pulse", pq[1].size(), 0);

    // btnU held 40 cycles; the repeat due on the falling edge is suppressed.
    clr();
    k = edge_no;
    repeat (40) cycle(1'b0, 5'b10000);
    idle(10);
    chk("rep_count", pq[4].size(), 11);
    chk("rep_press", pe(4, 0), k + 5);
    chk("rep_first", pe(4, 1), k + 15);
    chk("rep_second", pe(4, 2), k + 18);
    chk("rep_last", pe(4, 10), k + 42);

    // btnL held 40 cycles: no auto-repeat.
    clr();
    repeat (40) cycle(1'b0, 5'b00100);
    idle(10);
    chk("norep_count", pq[2].size(), 1);

    // btnL and btnR together.
    clr();
    k = edge_no;
    repeat (8) cycle(1'b0, 5'b00110);
    chk("simul_any", int'(any_held), 1);
    chk("simul_r_count", pq[1].size(), 1);
    chk("simul_l_count", pq[2].size(), 1);
    chk("simul_r_edge", pe(1, 0), k + 5);
    chk("simul_l_edge", pe(2, 0), k + 5);
    idle(10);

    // btnD held through a 2-cycle reset while repeating.
    clr();
    k = edge_no;
    repeat (20) cycle(1'b0, 5'b01000);
    chk("hold_repeat_seen", pe(3, 1), k + 15);
    cycle(1'b1, 5'b01000);
    chk("midrst_level", int'(btn_level), 0);
    chk("midrst_pulse", int'(btn_pulse), 0);
    chk("midrst_any", int'(any_held), 0);
    cycle(1'b1, 5'b01000);
    clr();
    k = edge_no;
    repeat (25) cycle(1'b0, 5'b01000);
    chk("post_rst_press", pe(3, 0), k + 5);
    chk("post_rst_rep1", pe(3, 1), k + 15);
    chk("post_rst_rep2", pe(3, 2), k + 18);
    idle(10);

    // Random traffic with varying bounce density and occasional resets.
    raw_r = '0;
    for (int blk = 0; blk < 6; blk++) begin
      rate = $urandom_range(3, 40);
      for (int n = 0; n < 500; n++) begin
        for (int b = 0; b < NB; b++)
          if ($urandom_range(0, rate - 1) == 0) raw_r[b] = ~raw_r[b];
        cycle(($urandom_range(0, 299) == 0), raw_r);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
